// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RISC-V func3 access codes,
// the controller-side state encoding and a timeout counter sizing helper.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } lsuStateT;

  localparam int MIN_TIMEOUT_WIDTH = 8;

  // Counter wide enough to hold the timeout value, never narrower than a byte.
  function automatic int timeoutWidth(input int cycles);
    int needed;
    needed = $clog2(cycles + 1);
    return (needed > MIN_TIMEOUT_WIDTH) ? needed : MIN_TIMEOUT_WIDTH;
  endfunction

endpackage

// File: rtl/load_store_unit_access_check.sv
// Combinational legality check for one load/store: func3 must name an access
// size valid for the direction, and the byte address must be size-aligned.
module lsu_access_check
  import lsu_pkg::*;
#(
  parameter int FUNC3_WIDTH = 3
) (
  input  logic                   write,
  input  logic [FUNC3_WIDTH-1:0] func3,
  input  logic [1:0]             addr,
  output logic                   legal
);

  logic halfAligned;
  logic wordAligned;

  assign halfAligned = ~addr[0];
  assign wordAligned = (addr == 2'b00);

  // NOTE: every path through always_comb assigns legal first, so no latch is inferred.
  always_comb begin
    legal = 1'b0;
    if (write) begin
      case (func3)
        FUNC3_WIDTH'(SB): legal = 1'b1;
        FUNC3_WIDTH'(SH): legal = halfAligned;
        FUNC3_WIDTH'(SW): legal = wordAligned;
        default:          legal = 1'b0;
      endcase
    end else begin
      case (func3)
        FUNC3_WIDTH'(LB),
        FUNC3_WIDTH'(LBU): legal = 1'b1;
        FUNC3_WIDTH'(LH),
        FUNC3_WIDTH'(LHU): legal = halfAligned;
        FUNC3_WIDTH'(LW):  legal = wordAligned;
        default:           legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory interface: one load/store in flight, legality
// check, enables held until mem_ready. Optional BUSY abort: define LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int FUNC3_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [FUNC3_WIDTH-1:0]   req_func3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     mem_write_En,
  output logic                     mem_read_En,
  output logic [FUNC3_WIDTH-1:0]   mem_func3,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic                     mem_ready
);

  lsuStateT state;
  logic     handshake;
  logic     reqLegal;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign handshake = req_valid && req_ready;

  lsu_access_check #(
    .FUNC3_WIDTH(FUNC3_WIDTH)
  ) accessCheck (
    .write(req_write),
    .func3(req_func3),
    .addr (req_addr[1:0]),
    .legal(reqLegal)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int TIMEOUT_WIDTH = timeoutWidth(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  // Counts BUSY edges already spent without mem_ready.
  logic [TIMEOUT_WIDTH-1:0] timeoutCount;
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so the controller never sees stale values.
      state        <= IDLE;
      mem_write_En <= 1'b0;
      mem_read_En  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      mem_func3    <= '0;
      mem_address  <= '0;
      mem_data_in  <= '0;
`ifdef LSU_TIMEOUT_EN
      timeoutCount <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            mem_func3   <= req_func3;
            mem_address <= req_addr;
            mem_data_in <= req_wdata;
            if (reqLegal) begin
              state        <= BUSY;
              mem_write_En <= req_write;
              mem_read_En  <= ~req_write;
`ifdef LSU_TIMEOUT_EN
              timeoutCount <= '0;
`endif
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end

        BUSY: begin
          if (mem_ready) begin
            // mem_read_En is still high here exactly when the access is a load.
            if (mem_read_En) begin
              rsp_rdata <= mem_data_out;
            end
            mem_write_En <= 1'b0;
            mem_read_En  <= 1'b0;
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b0;
          end
`ifdef LSU_TIMEOUT_EN
          else if (timeoutCount == TIMEOUT_LAST) begin
            mem_write_En <= 1'b0;
            mem_read_En  <= 1'b0;
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b1;
          end else begin
            timeoutCount <= timeoutCount + 1'b1;
          end
`endif
        end

        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          mem_write_En <= 1'b0;
          mem_read_En  <= 1'b0;
          rsp_valid    <= 1'b0;
          rsp_err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory request interface; the data-memory controller is the responder.
- Sits between the processor's MEM stage and the data-memory controller.
- Accepts one load/store per handshake and checks func3 legality and address alignment.
- Drives the controller's write/read enables until it returns ready, then returns one response (load data or store completion) to the pipeline.

Parameters:
- DATA_WIDTH, 32, width of load/store data.
- ADDRESS_WIDTH, 32, width of byte address.
- FUNC3_WIDTH, 3, width of the access-size/sign code.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  LSU can accept a request; high exactly when state is IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_func3  in  FUNC3_WIDTH  RISC-V load/store func3.
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  load data; holds its last value otherwise.
- rsp_err  out  1  qualifies rsp_valid: misaligned, illegal func3, or timeout.
- busy  out  1  state is not IDLE; used by hazard logic to stall.
- mem_write_En  out  1  store enable to the controller.
- mem_read_En  out  1  load enable to the controller.
- mem_func3  out  FUNC3_WIDTH  forwarded func3.
- mem_address  out  ADDRESS_WIDTH  forwarded address.
- mem_data_in  out  DATA_WIDTH  store data.
- mem_data_out  in  DATA_WIDTH  controller read data, valid when mem_ready is high.
- mem_ready  in  1  controller completion.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state goes to IDLE.
  - mem_write_En, mem_read_En, rsp_valid, rsp_err and busy are 0.
  - rsp_rdata, mem_func3, mem_address and mem_data_in are 0.
  - Reset mid-transaction: enables drop the next cycle and no response is issued.
- All outputs are registered except req_ready and busy, which decode state.
- IDLE:
  - A handshake is req_valid && req_ready at an edge; the request fields are latched.
  - Legal request (alignment and func3 OK): go to BUSY. mem_read_En (load) or mem_write_En (store) is high from the next cycle.
  - Illegal request: go to RESP with rsp_err=1 and no memory access.
- Legality:
  - Loads: func3 must be one of 0,1,2,4,5.
  - Stores: func3 must be one of 0,1,2.
  - Halfword (func3[1:0]=1) needs addr[0]=0.
  - Word (func3[1:0]=2) needs addr[1:0]=0.
- BUSY:
  - Enable, mem_func3, mem_address and mem_data_in are held stable.
  - mem_ready is sampled every edge.
  - On mem_ready=1: the enable deasserts next cycle; loads capture mem_data_out into rsp_rdata; go to RESP with rsp_err=0.
  - Stores leave rsp_rdata unchanged.
- RESP: rsp_valid=1 for exactly this cycle; req_ready=0; return to IDLE.
- mem_ready is ignored outside BUSY.
- Latency:
  - Handshake at edge N with mem_ready seen at edge N+1 gives rsp_valid high in cycle N+2.
  - The earliest next handshake is edge N+3.
  - An illegal request gives rsp_valid in cycle N+1.
- Never more than one outstanding request; the controller never sees both enables high.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Enabled:
  - An 8+ bit counter is cleared on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without mem_ready: deassert the enable, go to RESP with rsp_err=1, rsp_rdata unchanged.
  - mem_ready on the same edge as the timeout wins, giving a normal completion.
- Disabled: no counter; BUSY waits indefinitely.

Decomposition:
- Package lsu_pkg:
  - func3 constants LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
  - state enum {IDLE, BUSY, RESP}.
- One combinational sub-module, lsu_access_check: inputs write, func3, addr[1:0]; output legal.

Test Plan:
- LW addr 0x10, mem_ready on 1st BUSY cycle with mem_data_out=0xDEADBEEF -> rsp_valid in cycle N+2, rsp_rdata=0xDEADBEEF, rsp_err=0; mem_read_En high exactly 1 cycle.
- SW addr 0x20 data 0x12345678, mem_ready after 3 cycles -> mem_write_En high 3 cycles with address/data stable; rsp_valid once; rsp_rdata unchanged.
- LH addr 0x13 -> no enable asserted; rsp_valid in cycle N+1 with rsp_err=1.
- Store func3=4 -> rsp_err=1 with no memory access.
- rst asserted in 2nd BUSY cycle -> enables 0 the next cycle, no rsp_valid, req_ready=1 after reset.
- Back-to-back req_valid held high with mem_ready always 1 -> handshakes every 3 cycles.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: mem_ready never arrives -> rsp_err=1 after 4 BUSY cycles.
